// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit: the divider state
// encoding, the native datapath width and two's-complement helpers.
package mdu_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Two's-complement negation, modulo 2^DIV_W (so -0x8000_0000 wraps to itself).
  function automatic logic [DIV_W-1:0] neg_val(input logic [DIV_W-1:0] v);
    return ~v + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

  // Sign bit of an operand; always 0 for an unsigned operation.
  function automatic logic sign_of(input logic [DIV_W-1:0] v, input logic is_signed);
    return is_signed & v[DIV_W-1];
  endfunction

  // Magnitude of an operand. The most negative value maps onto itself, which is
  // the correct magnitude once the result is read as unsigned.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic is_signed);
    logic [DIV_W-1:0] r;
    if (sign_of(v, is_signed)) begin
      r = neg_val(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_iter_unit_chk.sv
// Protocol checker for div_iter_unit, attached to every instance by bind.
module div_iter_unit_chk
  import mdu_pkg::*;
(
  input logic       clk,
  input logic       resetn,
  input logic       div_validE,
  input logic       flush,
  input div_state_t state,
  input logic       alu_stallE,
  input logic       div_ready
);

  // The instruction must stay in EX for the whole iteration unless flushed.
  a_valid_held_in_busy: assert property (
    @(posedge clk) disable iff (!resetn)
    (state == BUSY && !flush) |-> div_validE
  );

  // The unit never holds the pipeline while it also presents a result.
  a_no_stall_with_ready: assert property (
    @(posedge clk) disable iff (!resetn)
    !(alu_stallE && div_ready)
  );

  // The state register only ever holds one of the three legal encodings.
  a_legal_state: assert property (
    @(posedge clk) disable iff (!resetn)
    (state == IDLE) || (state == BUSY) || (state == DONE)
  );

endmodule

bind div_iter_unit div_iter_unit_chk u_div_iter_unit_chk (
  .clk        (clk),
  .resetn     (resetn),
  .div_validE (div_validE),
  .flush      (flush),
  .state      (state_r),
  .alu_stallE (alu_stallE),
  .div_ready  (div_ready)
);

// File: rtl/div_step.sv
// One radix-2 restoring division step. The partial remainder takes in the
// next dividend bit (MSB of quo_i), the divisor is subtracted when it fits,
// and the resulting quotient bit is shifted into the LSB of quo_o.
module div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] rem_diff_s;
  logic             fits_s;

  // Shift, trial-compare on WIDTH+1 bits, then restore or keep the difference.
  always_comb begin
    rem_shift_s = {rem_i, quo_i[WIDTH-1]};
    fits_s      = (rem_shift_s >= {1'b0, divisor_i});
    // When the divisor fits, the difference is below the divisor, so the
    // low WIDTH bits of the subtraction are the complete result.
    rem_diff_s  = rem_shift_s[WIDTH-1:0] - divisor_i;
    if (fits_s) begin
      rem_o = rem_diff_s;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_shift_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX. It holds the
// pipeline through alu_stallE while iterating, then presents the remainder on
// hi_o and the quotient on lo_o until the instruction leaves EX.
module div_iter_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_validE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] dividendE,
  input  logic [WIDTH-1:0] divisorE,
  input  logic             stall_ext,
  input  logic             flush,
  output logic             alu_stallE,
  output logic             div_ready,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  div_state_t       state_r;
  div_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             qneg_r;
  logic             rneg_r;
  logic             ready_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;
  logic             accept_s;
  logic             last_step_s;

  // The single iteration stage, reused once per BUSY cycle.
  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_r),
    .quo_i     (quo_r),
    .divisor_i (dvsr_r),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and the combinational handshake outputs; flush overrides all.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_step_s = 1'b0;
    alu_stallE  = div_validE & ~flush & (state_r != DONE);
    div_ready   = ready_r & ~flush;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (div_validE) begin
            accept_s    = 1'b1;
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            last_step_s = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        DONE: begin
          // Stay put while EX is held; otherwise the instruction moves on.
          if (stall_ext) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Iteration datapath: load magnitudes on accept, then one step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvsr_r <= '0;
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r  <= '0;
      rem_r  <= '0;
      quo_r  <= abs_val(dividendE, div_signedE);
      dvsr_r <= abs_val(divisorE, div_signedE);
      qneg_r <= sign_of(dividendE, div_signedE) ^ sign_of(divisorE, div_signedE);
      rneg_r <= sign_of(dividendE, div_signedE);
    end else if (state_r == BUSY && !flush) begin
      cnt_r <= cnt_r + CNT_W'(1);
      rem_r <= step_rem_s;
      quo_r <= step_quo_s;
    end else begin
      cnt_r <= cnt_r;
      rem_r <= rem_r;
      quo_r <= quo_r;
    end
  end

  // Result registers: sign-correct on the final step, hold through DONE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_r <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (flush) begin
      ready_r <= 1'b0;
    end else if (last_step_s) begin
      ready_r <= 1'b1;
      if (qneg_r) begin
        lo_r <= neg_val(step_quo_s);
      end else begin
        lo_r <= step_quo_s;
      end
      if (rneg_r) begin
        hi_r <= neg_val(step_rem_s);
      end else begin
        hi_r <= step_rem_s;
      end
    end else if (state_r == DONE && !stall_ext) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= ready_r;
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: a cycle-level reference model with plain
// arithmetic results, a per-cycle compare process, and literal expectations.
module tb_div_iter_unit;

  logic        clk;
  logic        resetn;
  logic        div_validE;
  logic        div_signedE;
  logic [31:0] dividendE;
  logic [31:0] divisorE;
  logic        stall_ext;
  logic        flush;
  logic        alu_stallE;
  logic        div_ready;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DONE = 2;

  int          m_phase;
  int          m_left;
  logic        m_ready;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  logic [63:0] cur_ref;

  div_iter_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .div_validE  (div_validE),
    .div_signedE (div_signedE),
    .dividendE   (dividendE),
    .divisorE    (divisorE),
    .stall_ext   (stall_ext),
    .flush       (flush),
    .alu_stallE  (alu_stallE),
    .div_ready   (div_ready),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo}: plain integer division, with the defined
  // divide-by-zero outcome (quotient of magnitude all-ones, remainder = dividend).
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [31:0] hi;
    logic [31:0] lo;
    if (b == 32'd0) begin
      hi = a;
      lo = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
    return {hi, lo};
  endfunction

  assign cur_ref = ref_div(div_signedE, dividendE, divisorE);

  // Timeline model: accept, 32 iteration cycles, then results until EX moves on.
  always @(posedge clk) begin
    if (!resetn) begin
      m_phase <= P_IDLE;
      m_left  <= 0;
      m_ready <= 1'b0;
      m_hi    <= 32'd0;
      m_lo    <= 32'd0;
      m_pend  <= 64'd0;
    end else if (flush) begin
      m_phase <= P_IDLE;
      m_ready <= 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (div_validE) begin
            m_phase <= P_BUSY;
            m_left  <= 32;
            m_pend  <= cur_ref;
          end
        end
        P_BUSY: begin
          if (m_left == 1) begin
            m_phase <= P_DONE;
            m_ready <= 1'b1;
            m_hi    <= m_pend[63:32];
            m_lo    <= m_pend[31:0];
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: begin
          if (!stall_ext) begin
            m_phase <= P_IDLE;
            m_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_stallE", 32'(alu_stallE), 32'(div_validE & ~flush & (m_phase != P_DONE)));
      chk("div_ready", 32'(div_ready), 32'(m_ready & ~flush));
      if (m_ready && !flush) begin
        chk("hi_o_model", hi_o, m_hi);
        chk("lo_o_model", lo_o, m_lo);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Present one division (caller is just past a posedge) and wait for the
  // result; returns at the negedge of the first result cycle, valid still high.
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int   stall_cnt;
    logic got;
    div_validE  = 1'b1;
    div_signedE = s;
    dividendE   = a;
    divisorE    = b;
    stall_cnt   = 0;
    got         = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (alu_stallE) begin
        stall_cnt++;
      end else if (div_ready) begin
        got = 1'b1;
      end
    end
    chk({name, "_done"}, 32'(got), 32'd1);
    chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
    chk({name, "_hi"}, hi_o, exp_hi);
    chk({name, "_lo"}, lo_o, exp_lo);
  endtask

  task automatic drop_valid();
    next_cycle();
    div_validE = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    div_validE  = 1'b0;
    div_signedE = 1'b0;
    dividendE   = 32'd0;
    divisorE    = 32'd0;
    stall_ext   = 1'b0;
    flush       = 1'b0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_stall", 32'(alu_stallE), 32'd0);
    chk("reset_ready", 32'(div_ready), 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // Basic unsigned and signed cases.
    run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);
    drop_valid();
    next_cycle();
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drop_valid();
    next_cycle();
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    drop_valid();
    next_cycle();

    // Divide by zero and the overflow case.
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    drop_valid();
    next_cycle();
    run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'd1);
    drop_valid();
    next_cycle();
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    drop_valid();
    next_cycle();

    // Flush during iteration, then a fresh op from IDLE.
    div_validE  = 1'b1;
    div_signedE = 1'b0;
    dividendE   = 32'd12345;
    divisorE    = 32'd3;
    repeat (10) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(alu_stallE), 32'd0);
    chk("flush_ready", 32'(div_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

    // Hold EX at DONE: results stay put and no restart happens.
    drop_valid();
    next_cycle();
    run_div("divu_ext", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);
    stall_ext = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(div_ready), 32'd1);
      chk("hold_stall", 32'(alu_stallE), 32'd0);
      chk("hold_hi", hi_o, 32'd15);
      chk("hold_lo", lo_o, 32'h0FFF_FFFF);
    end
    stall_ext = 1'b0;
    drop_valid();
    @(negedge clk);
    chk("release_ready", 32'(div_ready), 32'd0);
    next_cycle();

    // Back-to-back: the second op enters EX right after the first leaves.
    run_div("b2b_1", 1'b0, 32'd1000, 32'd10, 32'd0, 32'd100);
    next_cycle();
    run_div("b2b_2", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    drop_valid();
    next_cycle();

    // Reset in the middle of an iteration.
    div_validE  = 1'b1;
    div_signedE = 1'b0;
    dividendE   = 32'd999;
    divisorE    = 32'd4;
    repeat (6) next_cycle();
    resetn     = 1'b0;
    div_validE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_stall", 32'(alu_stallE), 32'd0);
    chk("rst_mid_ready", 32'(div_ready), 32'd0);
    chk("rst_mid_hi", hi_o, 32'd0);
    chk("rst_mid_lo", lo_o, 32'd0);
    next_cycle();
    resetn = 1'b1;
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
